term_writer: RTL
================

TERM_WRITER -- requirements
Module: term_writer

Interface
REQ-001 Parameter COLS, default 64, text columns (max 64).
REQ-002 Parameter ROWS, default 30, text rows (max 32).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_data  input  8  received byte (ASCII).
REQ-006 i_valid  input  1  i_data valid.
REQ-007 o_ready  output  1  block can accept a byte; transfer occurs when i_valid & o_ready at a rising edge.
REQ-008 o_wr_cell_x  output  6  logical column of write cell, feeds blinking-cursor stage.
REQ-009 o_wr_cell_y  output  5  logical row of write cell, feeds blinking-cursor stage.
REQ-010 o_ram_addr  output  11  char RAM address = {physical row[4:0], column[5:0]}.
REQ-011 o_ram_data  output  8  char RAM write data.
REQ-012 o_ram_we  output  1  char RAM write strobe, one cycle per cell.
REQ-013 o_scroll  output  5  physical RAM row shown as logical row 0.

Function
REQ-014 Physical row = (logical row + o_scroll) mod ROWS; no out-of-range row is ever addressed.
REQ-015 States: CLR_ALL, IDLE, PUT, CLR_LINE; o_ready SHALL be 1 only in IDLE.
REQ-016 IDLE, accepted byte 0x20..0x7E: next cycle state PUT with o_ram_we=1, o_ram_addr = current cursor cell, o_ram_data = byte; cursor advances in the same cycle; return to IDLE after one cycle (latency 1, throughput one byte per 2 cycles).
REQ-017 Advance: x<COLS-1 -> x+1; x=COLS-1 -> x=0 plus line feed (REQ-019).
REQ-018 0x0D (CR): x=0, no RAM write, stay IDLE.
REQ-019 0x0A (LF): y<ROWS-1 -> y+1, stay IDLE; y=ROWS-1 -> y unchanged, o_scroll=(o_scroll+1) mod ROWS, enter CLR_LINE.
REQ-020 CLR_LINE: write 0x20 to columns 0..COLS-1 of new bottom physical row, one per cycle, ascending; then IDLE (exactly COLS write cycles).
REQ-021 0x08 (BS): x>0 -> x-1; x=0 -> no change; no RAM write.
REQ-022 0x0C (FF): enter CLR_ALL; x=0, y=0, o_scroll=0.
REQ-023 CLR_ALL: write 0x20 to every cell, physical row 0..ROWS-1, column 0..COLS-1, row-major, one per cycle (ROWS*COLS cycles), then IDLE.
REQ-024 All other bytes (0x00..0x1F not listed, 0x7F..0xFF): accepted, discarded, no state change.
REQ-025 Wrap at last cell (x=COLS-1, y=ROWS-1) with printable byte: PUT writes the cell, then CLR_LINE follows immediately, cursor lands at (0, ROWS-1).
REQ-026 o_ram_we SHALL be 0 in IDLE; o_ram_addr/o_ram_data are don't-care when o_ram_we=0.
REQ-027 i_valid while o_ready=0 SHALL be ignored; byte held by upstream until accepted.

Reset
REQ-028 On i_rstn low: x=0, y=0, o_scroll=0, o_ram_we=0, o_ready=0, state CLR_ALL with clear counter 0.
REQ-029 After release, CLR_ALL runs to completion before first byte accepted; reset asserted mid-operation aborts any clear and restarts CLR_ALL.

Structure
REQ-030 Shared package term_pkg holds COLS/ROWS defaults, control codes (CR, LF, BS, FF, SPACE), state enumeration.
REQ-031 No sub-module required; clear sequencer (11-bit counter) and modulo row mapper SHALL be inline.

Verification
REQ-032 Reset release -> 1920 consecutive we cycles of 0x20 covering addr rows 0..29 cols 0..63, then o_ready=1, cursor (0,0).
REQ-033 Send 'A' at (0,0) -> one cycle later we=1, addr=0x000, data=0x41; cursor (1,0).
REQ-034 Cursor (63,5), send 'Z' -> write at {5,63}; cursor (0,6); no clear.
REQ-035 Cursor (10,29), scroll 0, send LF -> o_scroll=1, 64 writes of 0x20 to row 0 cols 0..63, o_ready low throughout, cursor (10,29); next 'B' writes physical row 0 col 10.
REQ-036 Cursor (0,3), send BS then CR then 0x1B -> cursor stays (0,3), no writes; then FF -> full 1920-cell clear, scroll 0, cursor (0,0).
REQ-037 Hold i_valid with 'C' during CLR_LINE; pulse i_rstn low mid-clear -> byte not taken until post-reset CLR_ALL finishes, then written at (0,0).

Source files
------------

// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared defaults, control codes, states and row mapping for term_writer
package term_pkg;

  localparam int DEF_COLS = 64;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    PUT      = 2'd2,
    CLR_LINE = 2'd3
  } state_t;

  // Both operands are below rows, so one conditional subtract is a full modulo.
  function automatic logic [4:0] row_map(input logic [4:0] row, input logic [4:0] scroll,
                                         input logic [5:0] rows);
    logic [5:0] sum;
    sum = {1'b0, row} + {1'b0, scroll};
    if (sum >= rows) sum = sum - rows;
    return sum[4:0];
  endfunction

endpackage

// File: rtl/term_writer.sv
// rtl/term_writer.sv - byte stream to character RAM writer with cursor, scrolling and screen clears
module term_writer
  import term_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [5:0]  o_wr_cell_x,
  output logic [4:0]  o_wr_cell_y,
  output logic [10:0] o_ram_addr,
  output logic [7:0]  o_ram_data,
  output logic        o_ram_we,
  output logic [4:0]  o_scroll
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [5:0] ROWS_W   = 6'(ROWS);

  state_t      state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [4:0]  scroll_q, scroll_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        clr_after_q, clr_after_d;
  logic        started_q, started_d;
  logic        printable;
  logic        do_lf;

  assign printable   = (i_data >= 8'h20) && (i_data <= 8'h7E);
  assign o_wr_cell_x = x_q;
  assign o_wr_cell_y = y_q;
  assign o_scroll    = scroll_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= CLR_ALL;
      x_q         <= '0;
      y_q         <= '0;
      scroll_q    <= '0;
      clr_cnt_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      clr_after_q <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      scroll_q    <= scroll_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      clr_after_q <= clr_after_d;
      started_q   <= started_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    scroll_d    = scroll_q;
    clr_cnt_d   = clr_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    clr_after_d = clr_after_q;
    started_d   = 1'b1;
    do_lf       = 1'b0;
    o_ready     = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_data  = CH_SPACE;

    case (state_q)
      // The first cycle after reset release is idle so no write overlaps reset.
      CLR_ALL: begin
        if (started_q) begin
          o_ram_we   = 1'b1;
          o_ram_addr = clr_cnt_q;
          if (clr_cnt_q[5:0] == LAST_COL) begin
            clr_cnt_d[5:0] = '0;
            if (clr_cnt_q[10:6] == LAST_ROW) begin
              clr_cnt_d = '0;
              state_d   = IDLE;
            end else begin
              clr_cnt_d[10:6] = clr_cnt_q[10:6] + 5'd1;
            end
          end else begin
            clr_cnt_d[5:0] = clr_cnt_q[5:0] + 6'd1;
          end
        end
      end

      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          if (printable) begin
            wr_addr_d = {row_map(y_q, scroll_q, ROWS_W), x_q};
            wr_data_d = i_data;
            state_d   = PUT;
            if (x_q != LAST_COL) begin
              x_d = x_q + 6'd1;
            end else begin
              x_d   = '0;
              do_lf = 1'b1;
            end
          end else begin
            case (i_data)
              CH_CR: x_d = '0;
              CH_LF: do_lf = 1'b1;
              CH_BS: if (x_q != '0) x_d = x_q - 6'd1;
              CH_FF: begin
                x_d       = '0;
                y_d       = '0;
                scroll_d  = '0;
                clr_cnt_d = '0;
                state_d   = CLR_ALL;
              end
              default: ;
            endcase
          end

          if (do_lf) begin
            if (y_q != LAST_ROW) begin
              y_d = y_q + 5'd1;
            end else begin
              scroll_d  = (scroll_q == LAST_ROW) ? 5'd0 : scroll_q + 5'd1;
              clr_cnt_d = '0;
              // A wrapping printable byte must still land before the bottom row is blanked.
              if (printable) clr_after_d = 1'b1;
              else           state_d     = CLR_LINE;
            end
          end
        end
      end

      PUT: begin
        o_ram_we    = 1'b1;
        o_ram_addr  = wr_addr_q;
        o_ram_data  = wr_data_q;
        clr_after_d = 1'b0;
        state_d     = clr_after_q ? CLR_LINE : IDLE;
      end

      CLR_LINE: begin
        o_ram_we   = 1'b1;
        o_ram_addr = {row_map(LAST_ROW, scroll_q, ROWS_W), clr_cnt_q[5:0]};
        if (clr_cnt_q[5:0] == LAST_COL) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d[5:0] = clr_cnt_q[5:0] + 6'd1;
        end
      end

      default: state_d = CLR_ALL;
    endcase
  end

endmodule
